// File: rtl/fex_issue_ctrl.sv
// FP-unit issue controller: tracks one in-flight FP op, counts its latency and
// arbitrates its writeback against the integer pipeline's use of the int write port.
package wi23_defs;
  localparam int REGFILE_DEPTH = 5;
endpackage

module fex_issue_ctrl
  import wi23_defs::*;
#(
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 16,
  parameter int LAT_CVT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_op,
  input  logic [REGFILE_DEPTH-1:0] issue_rd,
  input  logic                     issue_rd_int,
  input  logic                     int_wb_busy,
  input  logic                     flush,
  output logic                     issue_ready,
  output logic                     fex_start,
  output logic                     fex_busy,
  output logic                     fex_busy_er,
  output logic                     pend_valid,
  output logic [REGFILE_DEPTH-1:0] pend_rd,
  output logic                     pend_int,
  output logic                     fex_wb_valid,
  output logic [REGFILE_DEPTH-1:0] fex_wb_rd,
  output logic                     fex_wb_int
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                     state_q;
  logic [4:0]                 cnt_q;
  logic                       pend_valid_q;
  logic [REGFILE_DEPTH-1:0]   pend_rd_q;
  logic                       pend_int_q;

  logic       wb_done;
  logic       accept;
  logic [4:0] lat_m1;

  // An int-destination writeback waits while the integer pipe owns the port.
  assign wb_done     = (state_q == WB) & ~flush & ~(pend_int_q & int_wb_busy);
  assign issue_ready = ~flush & ((state_q == IDLE) | wb_done);
  assign accept      = issue_valid & issue_ready;

  always_comb begin
    lat_m1 = 5'(LAT_ADD - 1);
    case (issue_op)
      2'b00:   lat_m1 = 5'(LAT_ADD - 1);
      2'b01:   lat_m1 = 5'(LAT_MUL - 1);
      2'b10:   lat_m1 = 5'(LAT_DIV - 1);
      default: lat_m1 = 5'(LAT_CVT - 1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_int_q   <= 1'b0;
    end else if (flush) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
    end else if (accept) begin
      state_q      <= EXEC;
      cnt_q        <= lat_m1;
      pend_rd_q    <= issue_rd;
      pend_int_q   <= issue_rd_int;
      pend_valid_q <= 1'b1;
    end else begin
      case (state_q)
        EXEC: begin
          if (cnt_q == 5'd1) state_q <= WB;
          else               cnt_q   <= cnt_q - 5'd1;
        end
        WB: begin
          if (wb_done) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fex_start    = accept;
  assign fex_busy     = (state_q != IDLE);
  assign fex_busy_er  = wb_done;
  assign pend_valid   = pend_valid_q;
  assign pend_rd      = pend_rd_q;
  assign pend_int     = pend_int_q;
  assign fex_wb_valid = wb_done;
  assign fex_wb_rd    = pend_rd_q;
  assign fex_wb_int   = pend_int_q;

endmodule

// File: tb/tb_fex_issue_ctrl.sv
// Bench for fex_issue_ctrl: a remaining-cycles model checked every cycle plus
// directed scenarios with literal expectations.
module tb_fex_issue_ctrl;
  import wi23_defs::*;

  logic clk = 1'b0;
  logic rst;
  logic issue_valid;
  logic [1:0] issue_op;
  logic [REGFILE_DEPTH-1:0] issue_rd;
  logic issue_rd_int;
  logic int_wb_busy;
  logic flush;
  logic issue_ready, fex_start, fex_busy, fex_busy_er;
  logic pend_valid, pend_int, fex_wb_valid, fex_wb_int;
  logic [REGFILE_DEPTH-1:0] pend_rd, fex_wb_rd;

  int errors = 0;
  int checks = 0;
  int wb_count = 0;

  fex_issue_ctrl dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_rd_int(issue_rd_int), .int_wb_busy(int_wb_busy),
    .flush(flush), .issue_ready(issue_ready), .fex_start(fex_start),
    .fex_busy(fex_busy), .fex_busy_er(fex_busy_er), .pend_valid(pend_valid),
    .pend_rd(pend_rd), .pend_int(pend_int), .fex_wb_valid(fex_wb_valid),
    .fex_wb_rd(fex_wb_rd), .fex_wb_int(fex_wb_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one op in flight; rem counts cycles until it may write back.
  bit m_busy;
  int m_rem;
  int m_rd;
  bit m_int;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00: return 3;
      2'b01: return 4;
      2'b10: return 16;
      default: return 2;
    endcase
  endfunction

  function automatic bit exp_done();
    return m_busy && m_rem == 0 && !flush && !(m_int && int_wb_busy);
  endfunction

  function automatic bit exp_ready();
    return !flush && (!m_busy || exp_done());
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_rem = 0; m_rd = 0; m_int = 0;
    end else if (flush) begin
      m_busy = 0;
    end else if (issue_valid && exp_ready()) begin
      m_busy = 1; m_rem = lat_of(issue_op) - 1; m_rd = int'(issue_rd); m_int = issue_rd_int;
    end else if (exp_done()) begin
      m_busy = 0;
    end else if (m_busy && m_rem > 0) begin
      m_rem--;
    end
  end

  always @(negedge clk) begin
    bit d, r;
    d = exp_done();
    r = exp_ready();
    chk("m_ready", int'(issue_ready), int'(r));
    chk("m_start", int'(fex_start), int'(issue_valid && r));
    chk("m_busy", int'(fex_busy), int'(m_busy));
    chk("m_busy_er", int'(fex_busy_er), int'(d));
    chk("m_wb_valid", int'(fex_wb_valid), int'(d));
    chk("m_pend_valid", int'(pend_valid), int'(m_busy));
    chk("m_pend_rd", int'(pend_rd), m_rd);
    chk("m_pend_int", int'(pend_int), int'(m_int));
    if (d) begin
      chk("m_wb_rd", int'(fex_wb_rd), m_rd);
      chk("m_wb_int", int'(fex_wb_int), int'(m_int));
    end
    if (fex_wb_valid) wb_count++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int rd, input logic is_int);
    issue_valid = 1'b1; issue_op = op; issue_rd = REGFILE_DEPTH'(rd); issue_rd_int = is_int;
  endtask

  initial begin
    int wbc;
    rst = 1'b1; issue_valid = 0; issue_op = 0; issue_rd = 0; issue_rd_int = 0;
    int_wb_busy = 0; flush = 0;
    #2;
    chk("rst_ready", int'(issue_ready), 1);
    chk("rst_busy", int'(fex_busy), 0);
    chk("rst_pend_valid", int'(pend_valid), 0);
    chk("rst_pend_rd", int'(pend_rd), 0);
    chk("rst_wb", int'(fex_wb_valid), 0);
    flush = 1; #1;
    chk("rst_ready_flush", int'(issue_ready), 0);
    flush = 0;
    cyc(2);
    rst = 1'b0;
    cyc();

    // mul rd=5: wb exactly 4 cycles after accept
    issue(2'b01, 5, 0); settle();
    chk("mul_start", int'(fex_start), 1);
    cyc(); issue_valid = 0; settle();
    for (int i = 1; i <= 3; i++) begin
      chk("mul_busy", int'(fex_busy), 1);
      chk("mul_no_wb", int'(fex_wb_valid), 0);
      cyc(); settle();
    end
    chk("mul_wb", int'(fex_wb_valid), 1);
    chk("mul_wb_rd", int'(fex_wb_rd), 5);
    chk("mul_busy_t4", int'(fex_busy), 1);
    cyc(); settle();
    chk("mul_idle_t5", int'(fex_busy), 0);

    // cvt rd=3 to int regfile, port busy T+2..T+4
    cyc();
    issue(2'b11, 3, 1); settle();
    chk("cvt_start", int'(fex_start), 1);
    cyc(); issue_valid = 0;
    cyc(); int_wb_busy = 1; settle();
    for (int i = 2; i <= 4; i++) begin
      chk("cvt_stall_wb", int'(fex_wb_valid), 0);
      chk("cvt_stall_er", int'(fex_busy_er), 0);
      chk("cvt_stall_pv", int'(pend_valid), 1);
      if (i < 4) begin cyc(); settle(); end
    end
    cyc(); int_wb_busy = 0; settle();
    chk("cvt_wb_t5", int'(fex_wb_valid), 1);
    chk("cvt_er_t5", int'(fex_busy_er), 1);
    chk("cvt_wb_rd", int'(fex_wb_rd), 3);
    chk("cvt_wb_int", int'(fex_wb_int), 1);
    cyc(); settle();
    chk("cvt_idle", int'(fex_busy), 0);

    // back-to-back: add rd=1 then cvt rd=2 held valid
    cyc();
    issue(2'b00, 1, 0); settle();
    chk("b2b_start0", int'(fex_start), 1);
    cyc(); issue(2'b11, 2, 0); settle();
    chk("b2b_hold1", int'(fex_start), 0);
    cyc(); settle();
    chk("b2b_hold2", int'(issue_ready), 0);
    cyc(); settle();
    chk("b2b_wb1", int'(fex_wb_valid), 1);
    chk("b2b_wb1_rd", int'(fex_wb_rd), 1);
    chk("b2b_start3", int'(fex_start), 1);
    cyc(); issue_valid = 0; settle();
    chk("b2b_t4_nowb", int'(fex_wb_valid), 0);
    cyc(); settle();
    chk("b2b_wb2", int'(fex_wb_valid), 1);
    chk("b2b_wb2_rd", int'(fex_wb_rd), 2);
    cyc();

    // FP destination never blocked by integer port
    int_wb_busy = 1;
    issue(2'b00, 6, 0);
    cyc(); issue_valid = 0;
    cyc(2); settle();
    chk("fp_noblock_wb", int'(fex_wb_valid), 1);
    chk("fp_noblock_rd", int'(fex_wb_rd), 6);
    cyc(); int_wb_busy = 0;

    // div rd=7 flushed at T+8
    wbc = wb_count;
    issue(2'b10, 7, 0);
    cyc(); issue_valid = 0;
    cyc(7); flush = 1; settle();
    chk("flush_ready", int'(issue_ready), 0);
    chk("flush_wb", int'(fex_wb_valid), 0);
    cyc(); flush = 0; settle();
    chk("flush_idle", int'(fex_busy), 0);
    chk("flush_pv", int'(pend_valid), 0);
    cyc(11);
    chk("flush_no_wb", wb_count, wbc);

    // async reset mid-EXEC of div
    issue(2'b10, 9, 1);
    cyc(); issue_valid = 0;
    cyc(4);
    wbc = wb_count;
    #2 rst = 1'b1; #1;
    chk("arst_busy", int'(fex_busy), 0);
    chk("arst_pv", int'(pend_valid), 0);
    chk("arst_rd", int'(pend_rd), 0);
    chk("arst_int", int'(pend_int), 0);
    chk("arst_ready", int'(issue_ready), 1);
    cyc(); rst = 1'b0;
    cyc(17);
    chk("arst_no_wb", wb_count, wbc);
    issue(2'b01, 4, 0); settle();
    chk("arst_reissue", int'(fex_start), 1);
    cyc(); issue_valid = 0;
    cyc(3); settle();
    chk("arst_wb", int'(fex_wb_valid), 1);
    chk("arst_wb_rd", int'(fex_wb_rd), 4);
    cyc();

    // issue with flush in IDLE is ignored
    flush = 1; issue(2'b00, 8, 0); settle();
    chk("flidle_start", int'(fex_start), 0);
    cyc(); flush = 0; issue_valid = 0; settle();
    chk("flidle_busy", int'(fex_busy), 0);
    chk("flidle_pv", int'(pend_valid), 0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fex_issue_ctrl.md
FEX_ISSUE_CTRL -- requirements
Module: fex_issue_ctrl

Interface
REQ-001 SHALL have parameters: LAT_ADD, default 3, add/sub latency; LAT_MUL, default 4, multiply latency; LAT_DIV, default 16, divide latency; LAT_CVT, default 2, convert latency.
REQ-002 SHALL use register-index width REGFILE_DEPTH from package wi23_defs.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 issue_valid  in  1  ID presents an FP-unit op this cycle.
REQ-006 issue_op  in  2  00 add/sub, 01 mul, 10 div, 11 cvt.
REQ-007 issue_rd  in  REGFILE_DEPTH  destination register index.
REQ-008 issue_rd_int  in  1  destination is the integer regfile; FP regfile when 0.
REQ-009 int_wb_busy  in  1  integer pipeline owns the integer write port this cycle.
REQ-010 flush  in  1  cancel in-flight FP op.
REQ-011 issue_ready  out  1  controller accepts an issue this cycle.
REQ-012 fex_start  out  1  one-cycle start pulse to the FP datapath.
REQ-013 fex_busy  out  1  op in flight.
REQ-014 fex_busy_er  out  1  early release: op in flight completes writeback this cycle.
REQ-015 pend_valid / pend_rd / pend_int  out  1 / REGFILE_DEPTH / 1  scoreboard entry for the hazard unit.
REQ-016 fex_wb_valid / fex_wb_rd / fex_wb_int  out  1 / REGFILE_DEPTH / 1  writeback strobe, index, target regfile.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, WB and a 5-bit down-counter cnt; every LAT_* SHALL lie in 2..31.
REQ-018 SHALL define accept = issue_valid & issue_ready; issue_ready = ~flush & (state==IDLE | (state==WB & wb_done)).
REQ-019 SHALL define wb_done = (state==WB) & ~flush & ~(pend_int & int_wb_busy).
REQ-020 fex_start SHALL equal accept combinationally.
REQ-021 On accept: next state EXEC, cnt <= selected LAT-1, pend_rd <= issue_rd, pend_int <= issue_rd_int, pend_valid <= 1.
REQ-022 In EXEC: cnt==1 -> WB; otherwise cnt decrements and state holds.
REQ-023 fex_wb_valid SHALL equal wb_done; fex_wb_rd = pend_rd, fex_wb_int = pend_int.
REQ-024 Accept in cycle T SHALL yield fex_wb_valid in cycle T+LAT when the write port is free.
REQ-025 In WB with pend_int=1 and int_wb_busy=1: state, pend_* SHALL hold; fex_wb_valid=0; FP-destination ops never block.
REQ-026 In WB with wb_done and no accept: next state IDLE, pend_valid <= 0; with wb_done and accept: REQ-021 applies (back-to-back).
REQ-027 fex_busy SHALL equal (state!=IDLE); fex_busy_er SHALL equal wb_done.
REQ-028 flush (any state) SHALL force next state IDLE, pend_valid <= 0, suppress fex_wb_valid and accept that cycle, and have priority over all other events.
REQ-029 issue_valid while issue_ready=0 SHALL be ignored with no state change.

Reset
REQ-030 rst high SHALL asynchronously force state IDLE, cnt 0, pend_valid 0, pend_rd 0, pend_int 0.
REQ-031 During and after reset all outputs SHALL be 0 except issue_ready = ~flush.
REQ-032 Reset mid-EXEC or mid-WB SHALL discard the op with no writeback pulse.

Verification
REQ-033 Issue op=01 rd=5 int=0 at T -> fex_start at T, fex_busy T+1..T+4, fex_wb_valid rd=5 at T+4, IDLE at T+5.
REQ-034 Issue op=11 rd=3 int=1, int_wb_busy=1 at T+2..T+4 -> wb stalls in WB, fex_wb_valid at T+5, fex_busy_er only at T+5.
REQ-035 Issue op=00 rd=1 at T, second issue op=11 rd=2 held valid -> accepted at T+3 alongside wb of rd=1, wb of rd=2 at T+5.
REQ-036 Issue op=10 rd=7 at T, flush at T+8 -> IDLE at T+9, pend_valid 0, no fex_wb_valid through T+20.
REQ-037 Assert rst asynchronously mid-EXEC of op=10 -> outputs 0 immediately, no writeback; issue after release accepted normally.
REQ-038 Issue_valid with flush=1 in IDLE -> no fex_start, state stays IDLE.
